// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: one valid/ready bus transaction per CPU data access, with lane steering and load extension.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus cycle that waits TIMEOUT cycles without bus_ready.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DONE = 2'd2} state_t;

  state_t      state_r, next_state_s;
  logic        req_s, fault_s, start_s, finish_s, abort_s;
  logic        stall_s, err_s, to_err_r;
  logic        bus_we_r, sign_ext_r;
  logic [1:0]  size_r, lane_r;
  logic [3:0]  bus_be_r;
  logic [31:0] bus_addr_r, bus_wdata_r, rdata_r, load_s;

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_w_check
    $error("CNT_W is too narrow to hold TIMEOUT");
  end

  function automatic logic access_fault(input logic rd, input logic wr,
                                        input logic [1:0] sz, input logic [1:0] lo);
    logic f;
    case (sz)
      2'b00:   f = 1'b0;
      2'b01:   f = lo[0];
      2'b10:   f = (lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f | (rd & wr);
  endfunction

  function automatic logic [3:0] steer_be(input logic [1:0] sz, input logic [1:0] lo, input logic we);
    logic [3:0] be;
    if (we) begin
      case (sz)
        2'b00:   be = 4'b0001 << lo;
        2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] sz, input logic [1:0] lo,
                                          input logic sx, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign req_s    = req_rd | req_wr;
  assign fault_s  = req_s & access_fault(req_rd, req_wr, size, addr[1:0]);
  assign start_s  = (state_r == ST_IDLE) & req_s & ~fault_s;
  assign finish_s = (state_r == ST_REQ) & (bus_ready | abort_s);
  assign load_s   = extract(size_r, lane_r, sign_ext_r, bus_rdata);

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;

  // Wait counter: counts REQ cycles, cleared whenever the bus cycle is not in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // Abort fires in the TIMEOUT-th REQ cycle so bus_valid is held exactly TIMEOUT cycles
  assign abort_s = (state_r == ST_REQ) & ~bus_ready & (cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign abort_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: next_state_s = start_s ? ST_REQ : ST_IDLE;
      ST_REQ:  next_state_s = (bus_ready | abort_s) ? ST_DONE : ST_REQ;
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Stall/err decode; gated by reset so both drop the moment reset asserts
  always_comb begin
    stall_s = 1'b0;
    err_s   = 1'b0;
    if (!rst) begin
      stall_s = 1'b0;
      err_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stall_s = req_s & ~fault_s;
          err_s   = fault_s;
        end
        ST_REQ:  stall_s = 1'b1;
        ST_DONE: err_s   = to_err_r;
        default: begin
          stall_s = 1'b0;
          err_s   = 1'b0;
        end
      endcase
    end
  end

  // Request capture at launch and load-result capture at completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_addr_r  <= 32'h0000_0000;
      bus_we_r    <= 1'b0;
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      size_r      <= 2'b00;
      sign_ext_r  <= 1'b0;
      lane_r      <= 2'b00;
      rdata_r     <= 32'h0000_0000;
      to_err_r    <= 1'b0;
    end else begin
      to_err_r <= abort_s;
      if (start_s) begin
        bus_addr_r  <= {addr[31:2], 2'b00};
        bus_we_r    <= req_wr;
        bus_be_r    <= steer_be(size, addr[1:0], req_wr);
        bus_wdata_r <= steer_wdata(size, wdata);
        size_r      <= size;
        sign_ext_r  <= sign_ext;
        lane_r      <= addr[1:0];
      end
      if (finish_s) begin
        rdata_r <= (bus_ready & ~bus_we_r) ? load_s : 32'h0000_0000;
      end
    end
  end

  assign stall     = stall_s;
  assign err       = err_s;
  assign bus_valid = (state_r == ST_REQ);
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_be    = bus_be_r;
  assign bus_wdata = bus_wdata_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: cycle-level expectations from a transaction model plus literal pins.
// Follows LSU_TIMEOUT_EN the same way as the design (timeout abort vs. indefinite wait).
module tb_lsu_bus_bridge;

  localparam int unsigned TO = 4;

  logic        clk, rst, req_rd, req_wr, sign_ext, bus_ready;
  logic [31:0] addr, wdata, bus_rdata;
  logic [1:0]  size;
  logic        stall, err, bus_valid, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  lsu_bus_bridge #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .wdata(wdata),
    .size(size), .sign_ext(sign_ext), .stall(stall), .rdata(rdata), .err(err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_valid, exp_err, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  int          stall_total = 0, valid_total = 0, err_total = 0;
  int          s0, v0, e0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic model_fault(input logic rd, input logic wr, input logic [1:0] sz,
                                       input logic [31:0] a);
    return (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
           (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input int unsigned lo, input logic we);
    logic [3:0] be;
    be = 4'hF;
    if (we && sz == 2'd0) begin
      for (int unsigned i = 0; i < 4; i++) be[i] = (i == lo);
    end else if (we && sz == 2'd1) begin
      for (int unsigned i = 0; i < 4; i++) be[i] = ((i / 2) == (lo / 2));
    end else begin
      be = 4'hF;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h0101_0101;
    else if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    else return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input int unsigned lo,
                                             input logic sx, input logic [31:0] d);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (d >> (8 * lo)) & 32'h0000_00FF;
      if (sx && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * (lo / 2))) & 32'h0000_FFFF;
      if (sx && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Per-cycle comparison against the model, plus bookkeeping for literal checks
  always @(negedge clk) begin
    if (chk_en) begin
      check32("stall", {31'h0, stall}, {31'h0, exp_stall});
      check32("err", {31'h0, err}, {31'h0, exp_err});
      check32("bus_valid", {31'h0, bus_valid}, {31'h0, exp_valid});
      check32("rdata", rdata, exp_rdata);
      if (exp_valid) begin
        check32("bus_we", {31'h0, bus_we}, {31'h0, exp_we});
        check32("bus_addr", bus_addr, exp_addr);
        check32("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
        check32("bus_wdata", bus_wdata, exp_wdata);
      end
    end
    if (stall) stall_total++;
    if (err) err_total++;
    if (bus_valid) begin
      valid_total++;
      seen_addr  = bus_addr;
      seen_be    = bus_be;
      seen_wdata = bus_wdata;
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
  endtask

  task automatic snap();
    s0 = stall_total; v0 = valid_total; e0 = err_total;
  endtask

  task automatic set_req_exp(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] sz);
    exp_stall = 1'b1; exp_valid = 1'b1; exp_err = 1'b0; exp_we = wr;
    exp_addr  = {a[31:2], 2'b00};
    exp_be    = model_be(sz, a[1:0], wr);
    exp_wdata = model_wdata(sz, wd);
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input logic sx);
    req_rd = rd; req_wr = wr; addr = a; wdata = wd; size = sz; sign_ext = sx; bus_ready = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sx, input int waits, input logic [31:0] rdat);
    logic flt;
    flt = model_fault(rd, wr, sz, a);
    @(posedge clk); #1;
    drive_req(rd, wr, a, wd, sz, sx);
    exp_valid = 1'b0; exp_stall = !flt; exp_err = flt;
    if (!flt) begin
      for (int i = 0; i <= waits; i++) begin
        @(posedge clk); #1;
        bus_ready = (i == waits);
        bus_rdata = (i == waits) ? rdat : ~rdat;
        set_req_exp(wr, a, wd, sz);
      end
      @(posedge clk); #1;
      bus_ready = 1'b0; bus_rdata = 32'h0;
      set_idle_exp();
      exp_rdata = wr ? 32'h0 : model_load(sz, a[1:0], sx, rdat);
    end
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0;
    set_idle_exp();
  endtask

  task automatic mid_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    set_idle_exp();
    exp_rdata = 32'h0;
    #1;
    check32("rst_async_stall", {31'h0, stall}, 32'h0);
    check32("rst_async_valid", {31'h0, bus_valid}, 32'h0);
    req_rd = 1'b0; req_wr = 1'b0; bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req_rd = 1'b0; req_wr = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'd0;
    sign_ext = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0;
    set_idle_exp(); exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_stall", {31'h0, stall}, 32'h0);
    check32("reset_err", {31'h0, err}, 32'h0);
    check32("reset_bus_valid", {31'h0, bus_valid}, 32'h0);
    check32("reset_bus_we", {31'h0, bus_we}, 32'h0);
    check32("reset_bus_addr", bus_addr, 32'h0);
    check32("reset_bus_wdata", bus_wdata, 32'h0);
    check32("reset_bus_be", {28'h0, bus_be}, 32'h0);
    check32("reset_rdata", rdata, 32'h0);
    rst = 1'b1; chk_en = 1'b1;

    snap();
    access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, 32'hDEADBEEF);
    check32("ldw_rdata", rdata, 32'hDEADBEEF);
    check32("ldw_bus_addr", seen_addr, 32'h100);
    check32("ldw_bus_be", {28'h0, seen_be}, 32'hF);
    check32("ldw_stall_cycles", stall_total - s0, 32'd2);

    snap();
    access(1'b0, 1'b1, 32'h203, 32'h0000_00A5, 2'd0, 1'b0, 3, 32'h0);
    check32("stb_bus_be", {28'h0, seen_be}, 32'h8);
    check32("stb_bus_wdata", seen_wdata, 32'hA5A5A5A5);
    check32("stb_valid_cycles", valid_total - v0, 32'd4);
    check32("stb_stall_cycles", stall_total - s0, 32'd5);
    check32("stb_rdata", rdata, 32'h0);

    access(1'b1, 1'b0, 32'h42, 32'h0, 2'd1, 1'b1, 1, 32'h8001_1234);
    check32("ldh_sx_rdata", rdata, 32'hFFFF8001);
    access(1'b1, 1'b0, 32'h42, 32'h0, 2'd1, 1'b0, 0, 32'h8001_1234);
    check32("ldh_zx_rdata", rdata, 32'h00008001);

    for (int i = 0; i < 3; i++) begin
      snap();
      case (i)
        0:       access(1'b1, 1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 0, 32'h0);
        1:       access(1'b1, 1'b1, 32'h100, 32'h0, 2'd2, 1'b0, 0, 32'h0);
        default: access(1'b1, 1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 0, 32'h0);
      endcase
      check32("fault_err_cycles", err_total - e0, 32'd1);
      check32("fault_valid_cycles", valid_total - v0, 32'd0);
      check32("fault_stall_cycles", stall_total - s0, 32'd0);
    end
    access(1'b0, 1'b1, 32'h0003, 32'h1234_5678, 2'd1, 1'b0, 0, 32'h0);

    for (int unsigned lane = 0; lane < 4; lane++) begin
      access(1'b1, 1'b0, 32'h400 + lane, 32'h0, 2'd0, 1'b1, int'(lane), 32'h80FF_7F01);
      access(1'b1, 1'b0, 32'h400 + lane, 32'h0, 2'd0, 1'b0, 0, 32'h80FF_7F01);
      access(1'b0, 1'b1, 32'h500 + lane, 32'hCAFE_0000 + lane, 2'd0, 1'b0, 0, 32'h0);
    end
    access(1'b0, 1'b1, 32'h602, 32'hAAAA_BEEF, 2'd1, 1'b0, 2, 32'h0);
    access(1'b0, 1'b1, 32'h600, 32'hAAAA_BEEF, 2'd1, 1'b0, 0, 32'h0);
    access(1'b0, 1'b1, 32'h7FC, 32'h0102_0304, 2'd2, 1'b0, 1, 32'h0);
    access(1'b1, 1'b0, 32'h800, 32'h0, 2'd1, 1'b1, 0, 32'h1234_7FFF);
    check32("ldh_pos_rdata", rdata, 32'h00007FFF);
    access(1'b1, 1'b0, 32'h801, 32'h0, 2'd0, 1'b1, 0, 32'h1234_80FF);
    check32("ldb_lane1_rdata", rdata, 32'hFFFFFF80);

    // Bus never answers
    snap();
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
    exp_stall = 1'b1; exp_valid = 1'b0; exp_err = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      @(posedge clk); #1;
      set_req_exp(1'b0, 32'h300, 32'h0, 2'd2);
    end
    @(posedge clk); #1;
    set_idle_exp(); exp_err = 1'b1; exp_rdata = 32'h0;
    @(posedge clk); #1;
    req_rd = 1'b0;
    set_idle_exp();
    check32("timeout_valid_cycles", valid_total - v0, TO);
    check32("timeout_err_cycles", err_total - e0, 32'd1);
    check32("timeout_rdata", rdata, 32'h0);
`else
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      set_req_exp(1'b0, 32'h300, 32'h0, 2'd2);
    end
    check32("hang_stall_cycles", stall_total - s0, 32'd40);
    mid_reset();
`endif

    // Reset during the second wait cycle of a store
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'h900, 32'h5555_AAAA, 2'd2, 1'b0);
    exp_stall = 1'b1; exp_valid = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_req_exp(1'b1, 32'h900, 32'h5555_AAAA, 2'd2);
    end
    mid_reset();
    check32("post_rst_rdata", rdata, 32'h0);
    access(1'b1, 1'b0, 32'hA00, 32'h0, 2'd2, 1'b0, 0, 32'h1357_9BDF);
    check32("post_rst_ldw_rdata", rdata, 32'h13579BDF);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the CPU execute/data-memory access point and an external valid/ready data bus with wait states.
- Takes a per-instruction load or store request (address from ALU result, store data from rs2/rt read port, access size) and runs one bus transaction.
- Holds a stall to control so PC write is suppressed until the access completes.
- Performs byte-lane steering for stores and extraction plus extension for loads.

Parameters:
- TIMEOUT, 255: bus wait-cycle limit before the access aborts with an error (used only with LSU_TIMEOUT_EN).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_rd  in  1  load request; held stable by the CPU while stall=1
- req_wr  in  1  store request; held stable while stall=1
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, right-justified
- size  in  2  00=byte, 01=half, 10=word, 11=reserved
- sign_ext  in  1  1=sign-extend loads, 0=zero-extend
- stall  out  1  1 = hold PC/pipeline
- rdata  out  32  extended load data, valid in DONE
- err  out  1  one-cycle pulse on a faulting access
- bus_valid  out  1  transaction request
- bus_we  out  1  1=write
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables (writes); 4'b1111 on reads
- bus_ready  in  1  slave accept/complete, same cycle as bus_valid
- bus_rdata  in  32  read data, valid when bus_ready=1 on a read

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0. Outputs: stall=0, err=0, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0. Reset mid-transaction drops bus_valid immediately; the slave must tolerate an abandoned request.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - No request: stall=0.
  - Fault conditions: req_rd&req_wr both 1, size=11, half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Fault: combinational err=1 for one cycle, stall=0, no bus cycle, stay IDLE. The CPU takes the trap path.
  - Valid request: stall=1 combinationally. Register bus_addr, bus_we, bus_be, bus_wdata, size, sign_ext and addr[1:0]. Go to REQ next edge.
- REQ:
  - bus_valid=1 with all bus outputs held stable; stall=1; counter increments each cycle.
  - bus_ready=1: capture bus_rdata on reads, then go to DONE.
- DONE:
  - stall=0; rdata valid (0 for stores).
  - The CPU commits at this edge; return to IDLE.
  - A request seen in the following IDLE cycle belongs to the next instruction.
- Latency, zero-wait slave: 3 cycles (IDLE, REQ, DONE) with stall high for 2. Each wait cycle adds 1.
- Store steering:
  - Byte: bus_wdata={4{wdata[7:0]}}, bus_be=4'b0001<<addr[1:0].
  - Half: bus_wdata={2{wdata[15:0]}}, bus_be=addr[1]?4'b1100:4'b0011.
  - Word: bus_wdata=wdata, bus_be=4'b1111.
- Load extraction:
  - Byte selects bus_rdata[8*addr[1:0]+:8]; half selects addr[1]?[31:16]:[15:0].
  - The selected value is extended to 32 bits per sign_ext.
- rdata holds its last value outside DONE. err is 0 outside fault cycles.

Optional Feature:
- LSU_TIMEOUT_EN defined: in REQ, if counter reaches TIMEOUT with bus_ready still 0, drop bus_valid, pulse err=1, set rdata=0, and go to DONE. The store is abandoned.
- Not defined: no counter logic; REQ waits indefinitely for bus_ready and err only reports alignment/encoding faults.

Test Plan:
- Word load, addr=0x100, slave ready on first REQ cycle with bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- Byte store, addr=0x203, wdata=0x000000A5, 3 wait cycles -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_valid held 4 cycles, stall high 5 cycles.
- Half load, addr=0x42, bus_rdata=0x8001_1234: sign_ext=1 -> rdata=0xFFFF8001; sign_ext=0 -> rdata=0x00008001.
- Misaligned word load, addr=0x101 -> err pulse 1 cycle, stall=0, bus_valid never asserted. Same response for req_rd=req_wr=1 and for size=11.
- LSU_TIMEOUT_EN with TIMEOUT=4 and bus_ready tied 0 -> bus_valid drops after 4 REQ cycles, err=1, DONE with rdata=0. Without the macro, stall stays 1 for the whole bench.
- Assert rst=0 during the 2nd wait cycle of a store -> bus_valid and stall go 0 asynchronously; after release the FSM is in IDLE and a new word load completes normally.
